// File: rtl/sipo_reg.sv
// sipo_reg: serial-in parallel-out word capture, MSB first, with an explicit IDLE/SHIFT/DONE FSM.
// Latency: WIDTH+1 rising edges from start sampled to valid (one start edge, then WIDTH en edges).
// Backpressure: none; en=0 in SHIFT stalls capture indefinitely, and start is ignored outside IDLE.
//
// Ports:
//   clk, rst_n   - clock and asynchronous active-low reset
//   start        - begin capturing a new word (sampled in IDLE only)
//   en, D        - bit strobe and serial data bit; D is taken only on edges where en=1
//   Q            - last completed word, held between completions
//   valid        - one-cycle pulse while the FSM is in DONE
//   busy         - high while in SHIFT
module sipo_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             en,
    input  logic             D,
    output logic [WIDTH-1:0] Q,
    output logic             valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Only the low WIDTH-1 bits of the shift register are ever needed: the
    // bit that would shift out of the top is never observed, and the final
    // bit goes straight from D into Q on the completing edge.
    logic [WIDTH-2:0] shreg;
    logic [WIDTH-1:0] shift_word;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    assign shift_word = {shreg, D};
    assign last_bit   = en && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
            Q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= '0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (en) begin
                        shreg <= shift_word[WIDTH-2:0];
                        // Wrap explicitly so the counter never passes WIDTH-1,
                        // even when WIDTH is not a power of two.
                        if (last_bit) begin
                            Q   <= shift_word;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (state == DONE);
    assign busy  = (state == SHIFT);

endmodule

// File: tb/tb_sipo_reg.sv
module tb_sipo_reg;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             en;
    logic             D;
    logic [WIDTH-1:0] Q;
    logic             valid;
    logic             busy;

    int n_tests;
    int n_fail;
    int cyc;

    // Scoreboard: expected words pushed when a word's stimulus starts,
    // observed words (and the edge they appeared on) pushed by step().
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got_q[$];
    int               got_cyc[$];

    sipo_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .en    (en),
        .D     (D),
        .Q     (Q),
        .valid (valid),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, take the rising edge, then sample 1ns later.
    task automatic step(input logic s, input logic e, input logic d);
        start = s;
        en    = e;
        D     = d;
        @(posedge clk);
        #1;
        cyc++;
        if (valid) begin
            got_q.push_back(Q);
            got_cyc.push_back(cyc);
        end
    endtask

    // Pop one observed word and compare against the scoreboard head.
    // Returns the edge number the word was observed on (or -1).
    task automatic pop_word(input string name, output int at_cyc);
        logic [WIDTH-1:0] e;
        at_cyc = -1;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected word queued, observed %0d words", name, got_q.size());
        end else if (got_q.size() == 0) begin
            e = exp_q.pop_front();
            n_fail++;
            $display("FAIL %s: no valid pulse seen, required Q=%h", name, e);
        end else begin
            e = exp_q.pop_front();
            at_cyc = got_cyc.pop_front();
            if (got_q.pop_front() !== e) begin
                n_fail++;
                $display("FAIL %s: Q at valid wrong, required %h", name, e);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        en    = 1'b0;
        D     = 1'b0;
        #3;
        n_tests++;
        if (Q !== '0) begin n_fail++; $display("FAIL reset_q: got %h, required 00", Q); end
        n_tests++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", valid); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        step(1'b1, 1'b1, 1'b1);    // inputs ignored while in reset
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b1);    // start=0 in IDLE: stay idle
        n_tests++;
        if (busy !== 1'b0 || valid !== 1'b0 || Q !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b valid=%b Q=%h, required 0 0 00", busy, valid, Q);
        end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] w;
        int s_cyc;
        int v_cyc;
        w = 8'hA5;
        exp_q.push_back(w);
        step(1'b1, 1'b0, 1'b0);
        s_cyc = cyc;
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, required 1", busy); end
        for (int i = WIDTH - 1; i >= 0; i--) step(1'b0, 1'b1, w[i]);
        pop_word("basic_q", v_cyc);
        n_tests++;
        if (v_cyc - s_cyc !== WIDTH) begin
            n_fail++;
            $display("FAIL basic_latency: valid %0d edges after start edge, required %0d", v_cyc - s_cyc, WIDTH);
        end
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (valid !== 1'b0 || busy !== 1'b0 || Q !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_after: valid=%b busy=%b Q=%h, required 0 0 a5", valid, busy, Q);
        end
    endtask

    task automatic test_gap();
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] old_q;
        int s_cyc;
        int v_cyc;
        int bad_hold;
        w        = 8'hA5;
        old_q    = 8'hA5;
        bad_hold = 0;
        exp_q.push_back(w);
        step(1'b1, 1'b0, 1'b0);
        s_cyc = cyc;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            step(1'b0, 1'b1, w[i]);
            if (i != 0 && (Q !== old_q || valid !== 1'b0)) bad_hold++;
            if (i == WIDTH - 4) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b0, ~w[i]);
                    if (Q !== old_q || valid !== 1'b0 || busy !== 1'b1) bad_hold++;
                end
            end
        end
        n_tests++;
        if (bad_hold !== 0) begin
            n_fail++;
            $display("FAIL gap_hold: %0d cycles with Q changed/valid/!busy mid-word, required 0", bad_hold);
        end
        pop_word("gap_q", v_cyc);
        n_tests++;
        if (v_cyc - s_cyc !== WIDTH + 3) begin
            n_fail++;
            $display("FAIL gap_latency: %0d edges, required %0d", v_cyc - s_cyc, WIDTH + 3);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_hold();
        int bad_q;
        int bad_v;
        int bad_b;
        bad_q = 0;
        bad_v = 0;
        bad_b = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
            if (Q !== 8'hA5) bad_q++;
            if (valid !== 1'b0) bad_v++;
            if (busy !== 1'b0) bad_b++;
        end
        n_tests++;
        if (bad_q !== 0) begin n_fail++; $display("FAIL hold_q: %0d cycles Q != a5, now %h", bad_q, Q); end
        n_tests++;
        if (bad_v !== 0) begin n_fail++; $display("FAIL hold_valid: %0d cycles valid=1, required 0", bad_v); end
        n_tests++;
        if (bad_b !== 0) begin n_fail++; $display("FAIL hold_busy: %0d cycles busy=1, required 0", bad_b); end
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic test_ignored_start();
        logic [WIDTH-1:0] w;
        int s_cyc;
        int v_cyc;
        w = 8'h3C;
        exp_q.push_back(w);
        step(1'b1, 1'b0, 1'b0);
        s_cyc = cyc;
        for (int i = WIDTH - 1; i >= 0; i--) step((i == WIDTH - 3) ? 1'b1 : 1'b0, 1'b1, w[i]);
        pop_word("ignstart_q", v_cyc);
        n_tests++;
        if (v_cyc - s_cyc !== WIDTH) begin
            n_fail++;
            $display("FAIL ignstart_latency: %0d edges, required %0d", v_cyc - s_cyc, WIDTH);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        logic [WIDTH-1:0] w;
        int v_cyc;
        // Restore Q=A5 first.
        w = 8'hA5;
        exp_q.push_back(w);
        step(1'b1, 1'b0, 1'b0);
        for (int i = WIDTH - 1; i >= 0; i--) step(1'b0, 1'b1, w[i]);
        pop_word("arst_setup_q", v_cyc);
        step(1'b0, 1'b0, 1'b0);
        // New word, abort during bit 5 (no scoreboard entry: it must never appear).
        w = 8'h5A;
        step(1'b1, 1'b0, 1'b0);
        for (int i = WIDTH - 1; i > WIDTH - 5; i--) step(1'b0, 1'b1, w[i]);
        en = 1'b1;
        D  = w[WIDTH-5];
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (Q !== '0 || busy !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: Q=%h busy=%b valid=%b, required 00 0 0", Q, busy, valid);
        end
        step(1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        w = 8'hFF;
        exp_q.push_back(w);
        step(1'b1, 1'b0, 1'b0);
        for (int i = WIDTH - 1; i >= 0; i--) step(1'b0, 1'b1, w[i]);
        pop_word("arst_after_q", v_cyc);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] w0;
        logic [WIDTH-1:0] w1;
        int c0;
        int c1;
        w0 = 8'h01;
        w1 = 8'h80;
        exp_q.push_back(w0);
        exp_q.push_back(w1);
        step(1'b1, 1'b0, 1'b0);
        for (int i = WIDTH - 1; i >= 0; i--) step(1'b0, 1'b1, w0[i]);
        step(1'b0, 1'b0, 1'b0);    // DONE -> IDLE
        step(1'b1, 1'b0, 1'b0);    // start in the IDLE cycle right after DONE
        for (int i = WIDTH - 1; i >= 0; i--) step(1'b0, 1'b1, w1[i]);
        step(1'b0, 1'b0, 1'b0);
        pop_word("b2b_q0", c0);
        pop_word("b2b_q1", c1);
        n_tests++;
        if (c1 - c0 !== WIDTH + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: %0d cycles between valids, required %0d", c1 - c0, WIDTH + 2);
        end
        n_tests++;
        if (got_q.size() !== 0 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d extra observed, %0d unmatched expected, required 0 0",
                     got_q.size(), exp_q.size());
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        test_reset();
        test_basic();
        test_gap();
        test_hold();
        test_ignored_start();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_reg.md
SIPO_REG -- requirements
Module: sipo_reg

Interface
REQ-001 Parameter: WIDTH, default 8, number of bits per word, minimum 2.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin capturing a new word.
REQ-005 Port: en  input  1  bit strobe; D is sampled only on edges where en=1.
REQ-006 Port: D  input  1  serial data bit, MSB first.
REQ-007 Port: Q  output  WIDTH  last completed parallel word, held between completions.
REQ-008 Port: valid  output  1  one-cycle pulse marking a new Q.
REQ-009 Port: busy  output  1  high while a word is being captured.

Function
REQ-010 The block SHALL implement the FSM states IDLE, SHIFT and DONE, all registered.
REQ-011 In IDLE with start=1 at a rising edge, the block SHALL clear the shift register, set the bit counter to 0 and enter SHIFT.
REQ-012 In IDLE with start=0, the block SHALL remain in IDLE and ignore en and D.
REQ-013 In SHIFT on an edge with en=1, the block SHALL shift left: shreg <= {shreg[WIDTH-2:0], D}, counter +1.
REQ-014 In SHIFT on an edge with en=0, the block SHALL hold shreg and the counter unchanged (no timeout).
REQ-015 On the edge where en=1 and counter = WIDTH-1, the block SHALL load Q with {shreg[WIDTH-2:0], D} and enter DONE.
REQ-016 valid SHALL be 1 exactly during the cycle the FSM is in DONE, and 0 otherwise.
REQ-017 DONE SHALL last one cycle and return unconditionally to IDLE; start in DONE is ignored.
REQ-018 start asserted during SHIFT SHALL be ignored (no restart, counter unaffected).
REQ-019 busy SHALL be 1 in SHIFT only, and 0 in IDLE and DONE.
REQ-020 Q SHALL change only on the DONE-entry edge or on reset; partial words are never visible on Q.
REQ-021 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.
REQ-022 Minimum word latency SHALL be WIDTH+1 edges from start sampled to valid high (1 start edge, then WIDTH en edges).
REQ-023 Back-to-back words: start may be asserted in the IDLE cycle right after DONE, giving a throughput of WIDTH+2 cycles per word.

Reset
REQ-024 When rst_n=0, the block SHALL immediately (without waiting for clk) force the FSM to IDLE, Q=0, shreg=0, counter=0, valid=0, busy=0.
REQ-025 Reset asserted mid-SHIFT SHALL discard the partial word; Q SHALL read 0, not the previous word.
REQ-026 After rst_n rises, the block SHALL ignore all inputs until the first rising edge and then follow REQ-011/REQ-012.

Verification (WIDTH=8)
REQ-027 Basic capture: start pulse, then 8 consecutive en=1 edges with D=1,0,1,0,0,1,0,1 -> Q=8'hA5, valid high for one cycle 9 edges after start, busy low afterwards.
REQ-028 Gapped strobe: same stream as REQ-027 with en=0 for 3 cycles after bit 4 -> Q=8'hA5, valid delayed by exactly 3 cycles, Q held at its old value throughout.
REQ-029 Hold: after Q=8'hA5, toggle D and en for 20 cycles with start=0 -> Q stays 8'hA5, valid stays 0, busy stays 0.
REQ-030 Ignored start: assert start at bit 3 of a stream of 8'h3C -> Q=8'h3C after 8 en edges total, with no restart.
REQ-031 Async reset: drop rst_n between clock edges during bit 5 of a new word while Q=8'hA5 -> Q=0, busy=0, valid=0 immediately; next start followed by 8'hFF yields Q=8'hFF.
REQ-032 Back-to-back: words 8'h01 then 8'h80, with start raised in the cycle after DONE -> two valid pulses 10 cycles apart, Q=8'h01 then 8'h80.
